virtual_input_ctrl: RTL
=======================

// Module: virtual_input_ctrl
// PURPOSE
//   Parametrised register bank for virtual DE2-115 push-buttons and slide switches, driven by indexed host commands.
//   Commands carry an index, an opcode and an asynchronous strobe. The strobe is synchronised into clk and edge-detected.
//   Supports toggle, set, release and reset-all; flags invalid indices. Sits between the host link and board-level logic.
// PARAMETERS
//   NUM_BUTTONS   4    number of active-low buttons
//   NUM_SWITCHES  18   number of active-high switches
//   IDX_W         5    width of cmd_index; 2**IDX_W >= NUM_BUTTONS+NUM_SWITCHES
//   SYNC_STAGES   2    strobe synchroniser depth (>=2)
//   PULSE_CYCLES  8    button press length, VIRTUAL_INPUT_PULSE_EN only (>=1)
// PORTS
//   clk         in   1             system clock
//   reset       in   1             synchronous, active-high
//   cmd_index   in   IDX_W         target index; held stable from strobe rise until cmd_ack/cmd_err
//   cmd_op      in   2             00 TOGGLE, 01 SET (assert), 10 RELEASE (deassert), 11 RESET_ALL
//   cmd_strobe  in   1             asynchronous command strobe; rising edge issues a command
//   buttons_n   out  NUM_BUTTONS   active-low button levels
//   switches    out  NUM_SWITCHES  switch levels
//   cmd_ack     out  1             1-cycle pulse: command applied
//   cmd_err     out  1             1-cycle pulse: command rejected
//   busy        out  1             button pulse in progress (0 without macro)
// BEHAVIOUR
//   Reset: buttons_n all 1, switches all 0, cmd_ack=cmd_err=busy=0, pulse counter 0.
//   Reset: synchroniser flops and edge register set to 1, so a strobe held high through reset issues no command.
//   Reset aborts any pulse in progress.
//   Edge detect: synchroniser output high while the previous synchroniser output was low.
//   Timing: strobe first sampled high at clk edge E0; cmd_index and cmd_op captured at edge E0+SYNC_STAGES.
//   Timing: outputs update and cmd_ack/cmd_err pulse at edge E0+SYNC_STAGES.
//   Index map: i < NUM_BUTTONS -> buttons_n[NUM_BUTTONS-1-i].
//   Index map: NUM_BUTTONS <= i < NUM_BUTTONS+NUM_SWITCHES -> switches[NUM_SWITCHES-1-(i-NUM_BUTTONS)].
//   Invalid index: i >= NUM_BUTTONS+NUM_SWITCHES.
//   TOGGLE inverts the target bit.
//   SET drives the target to its asserted level: button 0, switch 1. Idempotent.
//   RELEASE drives the target to its deasserted level: button 1, switch 0. Idempotent.
//   RESET_ALL restores all reset values and ignores cmd_index. Always acked; also aborts a pulse.
//   Invalid index with ops 00-10: cmd_err pulses, no output changes.
//   cmd_ack and cmd_err are mutually exclusive. At most one command per strobe edge.
//   Strobe high time and low time: each >= SYNC_STAGES+1 clk periods.
//   reset has priority over any detected edge in the same cycle.
// CONFIGURATION
//   VIRTUAL_INPUT_PULSE_EN defined: TOGGLE on a button index is momentary.
//     Target bit goes 0 and busy goes 1 at the apply edge, for exactly PULSE_CYCLES cycles; then bit returns to 1 and busy to 0.
//     cmd_ack pulses at the start of the press. One pulse engine.
//     While busy, any button-index command -> cmd_err, ignored. Switch commands and RESET_ALL are still accepted.
//     Counter width $clog2(PULSE_CYCLES+1).
//   VIRTUAL_INPUT_PULSE_EN undefined: TOGGLE on a button inverts its level like a switch.
//     busy is tied 0; no counter is instantiated.
// TESTING
//   (defaults; PULSE_CYCLES=8)
//   T1 reset asserted 3 cycles, strobe high throughout -> buttons_n=4'hF, switches=0, no ack after release of reset.
//   T2 index 4 TOGGLE strobe -> switches[17]=1 with one cmd_ack; repeat -> switches[17]=0.
//   T3 index 21 SET twice -> switches[0]=1 both times, two acks; then RELEASE -> switches[0]=0.
//   T4 index 22 TOGGLE -> one cmd_err pulse, no cmd_ack, buttons_n/switches unchanged.
//   T5 set switches 0,5,17 and index 1 SET (buttons_n[2]=0); then RESET_ALL idx 31 -> buttons_n=4'hF, switches=0, ack.
//   T6 macro on: index 0 TOGGLE -> buttons_n[3]=0 and busy=1 for exactly 8 cycles, then 1/0.
//   T6 macro on: index 2 cmd mid-pulse -> cmd_err.
//   T6 macro off: index 0 TOGGLE -> buttons_n[3] stays 0 until next TOGGLE.

Source files
------------

// File: rtl/virtual_input_ctrl.sv
// virtual_input_ctrl: virtual push-buttons (active-low) and slide switches, updated by indexed host commands.
// Define VIRTUAL_INPUT_PULSE_EN to make button TOGGLE a momentary press of PULSE_CYCLES clocks.
module virtual_input_ctrl #(
  parameter int NUM_BUTTONS  = 4,
  parameter int NUM_SWITCHES = 18,
  parameter int IDX_W        = 5,
  parameter int SYNC_STAGES  = 2,
  parameter int PULSE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [IDX_W-1:0]        cmd_index,
  input  logic [1:0]              cmd_op,
  input  logic                    cmd_strobe,
  output logic [NUM_BUTTONS-1:0]  buttons_n,
  output logic [NUM_SWITCHES-1:0] switches,
  output logic                    cmd_ack,
  output logic                    cmd_err,
  output logic                    busy
);

  localparam int NUM_TARGETS = NUM_BUTTONS + NUM_SWITCHES;

  typedef enum logic [1:0] {
    OP_TOGGLE    = 2'b00,
    OP_SET       = 2'b01,
    OP_RELEASE   = 2'b10,
    OP_RESET_ALL = 2'b11
  } op_e;

  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic                    strobe_prev_q, strobe_prev_d;
  logic                    strobe_edge;
  logic [NUM_BUTTONS-1:0]  buttons_n_q, buttons_n_d;
  logic [NUM_SWITCHES-1:0] switches_q, switches_d;
  logic                    cmd_ack_q, cmd_ack_d;
  logic                    cmd_err_q, cmd_err_d;

  logic [31:0]             idx_ext;
  logic                    idx_valid;
  logic                    idx_is_btn;
  logic [NUM_BUTTONS-1:0]  btn_mask;
  logic [NUM_SWITCHES-1:0] sw_mask;

`ifdef VIRTUAL_INPUT_PULSE_EN
  localparam int CNT_W = $clog2(PULSE_CYCLES + 1);
  logic [CNT_W-1:0]        pulse_cnt_q, pulse_cnt_d;
  logic [NUM_BUTTONS-1:0]  pulse_mask_q, pulse_mask_d;
  logic                    busy_q, busy_d;
`endif

  // Edge register starts at 1 so a strobe already high when reset drops is not a command.
  assign strobe_edge = sync_q[SYNC_STAGES-1] & ~strobe_prev_q;

  // Decode the command index into one-hot button/switch masks (bit order is reversed).
  always_comb begin
    idx_ext    = {{(32-IDX_W){1'b0}}, cmd_index};
    idx_valid  = (idx_ext < 32'(NUM_TARGETS));
    idx_is_btn = (idx_ext < 32'(NUM_BUTTONS));
    for (int b = 0; b < NUM_BUTTONS; b++) begin
      btn_mask[b] = (idx_ext == 32'(NUM_BUTTONS - 1 - b));
    end
    for (int s = 0; s < NUM_SWITCHES; s++) begin
      sw_mask[s] = (idx_ext == 32'(NUM_TARGETS - 1 - s));
    end
  end

  // Next-state logic: synchroniser, pulse engine and command application.
  always_comb begin
    sync_d        = {sync_q[SYNC_STAGES-2:0], cmd_strobe};
    strobe_prev_d = sync_q[SYNC_STAGES-1];
    buttons_n_d   = buttons_n_q;
    switches_d    = switches_q;
    cmd_ack_d     = 1'b0;
    cmd_err_d     = 1'b0;
`ifdef VIRTUAL_INPUT_PULSE_EN
    pulse_cnt_d   = pulse_cnt_q;
    pulse_mask_d  = pulse_mask_q;
    if (pulse_cnt_q != {CNT_W{1'b0}}) begin
      pulse_cnt_d = pulse_cnt_q - CNT_W'(1);
      if (pulse_cnt_q == CNT_W'(1)) begin
        buttons_n_d = buttons_n_d | pulse_mask_q;
      end else begin
        buttons_n_d = buttons_n_d;
      end
    end else begin
      pulse_cnt_d = pulse_cnt_q;
    end
`endif

    if (strobe_edge) begin
      case (cmd_op)
        OP_RESET_ALL: begin
          buttons_n_d = {NUM_BUTTONS{1'b1}};
          switches_d  = {NUM_SWITCHES{1'b0}};
          cmd_ack_d   = 1'b1;
`ifdef VIRTUAL_INPUT_PULSE_EN
          pulse_cnt_d = {CNT_W{1'b0}};
`endif
        end
        default: begin
          if (!idx_valid) begin
            cmd_err_d = 1'b1;
`ifdef VIRTUAL_INPUT_PULSE_EN
          end else if (idx_is_btn && busy_q) begin
            cmd_err_d = 1'b1;
`endif
          end else begin
            cmd_ack_d = 1'b1;
            case (cmd_op)
              OP_TOGGLE: begin
                if (idx_is_btn) begin
`ifdef VIRTUAL_INPUT_PULSE_EN
                  buttons_n_d  = buttons_n_d & ~btn_mask;
                  pulse_cnt_d  = CNT_W'(PULSE_CYCLES);
                  pulse_mask_d = btn_mask;
`else
                  buttons_n_d  = buttons_n_d ^ btn_mask;
`endif
                end else begin
                  switches_d = switches_d ^ sw_mask;
                end
              end
              OP_SET: begin
                buttons_n_d = buttons_n_d & ~btn_mask;
                switches_d  = switches_d | sw_mask;
              end
              OP_RELEASE: begin
                buttons_n_d = buttons_n_d | btn_mask;
                switches_d  = switches_d & ~sw_mask;
              end
              default: begin
                buttons_n_d = buttons_n_d;
                switches_d  = switches_d;
              end
            endcase
          end
        end
      endcase
    end else begin
      cmd_ack_d = 1'b0;
      cmd_err_d = 1'b0;
    end

`ifdef VIRTUAL_INPUT_PULSE_EN
    busy_d = (pulse_cnt_d != {CNT_W{1'b0}});
`endif
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q        <= {SYNC_STAGES{1'b1}};
      strobe_prev_q <= 1'b1;
      buttons_n_q   <= {NUM_BUTTONS{1'b1}};
      switches_q    <= {NUM_SWITCHES{1'b0}};
      cmd_ack_q     <= 1'b0;
      cmd_err_q     <= 1'b0;
`ifdef VIRTUAL_INPUT_PULSE_EN
      pulse_cnt_q   <= {CNT_W{1'b0}};
      pulse_mask_q  <= {NUM_BUTTONS{1'b0}};
      busy_q        <= 1'b0;
`endif
    end else begin
      sync_q        <= sync_d;
      strobe_prev_q <= strobe_prev_d;
      buttons_n_q   <= buttons_n_d;
      switches_q    <= switches_d;
      cmd_ack_q     <= cmd_ack_d;
      cmd_err_q     <= cmd_err_d;
`ifdef VIRTUAL_INPUT_PULSE_EN
      pulse_cnt_q   <= pulse_cnt_d;
      pulse_mask_q  <= pulse_mask_d;
      busy_q        <= busy_d;
`endif
    end
  end

  assign buttons_n = buttons_n_q;
  assign switches  = switches_q;
  assign cmd_ack   = cmd_ack_q;
  assign cmd_err   = cmd_err_q;
`ifdef VIRTUAL_INPUT_PULSE_EN
  assign busy      = busy_q;
`else
  assign busy      = 1'b0;
`endif

endmodule
